// File: rtl/qkv_pkg.sv
// Shared types for the Q/K/V fetch scheduler: FSM states, matrix
// select codes, slot index type and matrix-walk helpers.
package qkv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST_ADDR,
        WAIT_SLOT,
        ISSUE,
        WAIT_DONE,
        FINISH
    } state_e;

    typedef logic slot_idx_t;

    localparam logic [2:0] SEL_Q = 3'd0;
    localparam logic [2:0] SEL_K = 3'd1;
    localparam logic [2:0] SEL_V = 3'd2;

    // Lowest set mask bit at or above 'from'; result is {found, idx}.
    // from == 3 naturally yields "not found".
    function automatic logic [2:0] pick_mat(
        input logic [2:0] mask,
        input logic [1:0] from
    );
        logic [2:0] r;
        r = 3'b000;
        for (int i = 2; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] sel_code(input logic [1:0] ptr);
        logic [2:0] c;
        case (ptr)
            2'd0:    c = SEL_Q;
            2'd1:    c = SEL_K;
            default: c = SEL_V;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pingpong_slot_tracker.sv
// Occupancy of the two ping-pong consumer slots.
// Ports: clk_i/rst_i, abort_i clears all, set_i/set_idx_i marks a
// slot full, clr_i/clr_idx_i frees a slot, full_o per-slot state.
module pingpong_slot_tracker
    import qkv_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       abort_i,
    input  logic       set_i,
    input  slot_idx_t  set_idx_i,
    input  logic       clr_i,
    input  slot_idx_t  clr_idx_i,
    output logic [1:0] full_o
);

    logic [1:0] full_q;
    logic [1:0] full_d;

    // Set is applied after clear so a same-slot collision ends full;
    // clearing an already empty slot is a no-op.
    always_comb begin
        full_d = full_q;
        if (clr_i) full_d[clr_idx_i] = 1'b0;
        if (set_i) full_d[set_idx_i] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= '0;
        end else if (abort_i) begin
            full_q <= '0;
        end else begin
            full_q <= full_d;
        end
    end

    assign full_o = full_q;

endmodule

// File: rtl/qkv_fetch_scheduler.sv
// Walks Q->K->V tile fetches into two ping-pong slots.
// Ports: start/abort/config from the layer controller, fetch_done/busy
// from the fetch engine, slot releases from the consumer; drives the
// fetch controls, tile_valid/slot status, busy and done.
module qkv_fetch_scheduler
    import qkv_pkg::*;
#(
    parameter int TILE_CNT_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [2:0]            mat_mask_i,
    input  logic [TILE_CNT_W-1:0] num_tiles_i,
    input  logic                  fetch_done_i,
    input  logic                  fetch_busy_i,
    input  logic                  slot_release_i,
    input  logic                  slot_release_idx_i,
    output logic                  start_fetch_o,
    output logic                  reset_addr_counter_o,
    output logic [2:0]            buffer_select_o,
    output logic                  tiles_control_o,
    output logic                  double_buffering_o,
    output logic                  tile_valid_o,
    output logic                  tile_slot_o,
    output logic [1:0]            slot_full_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [TILE_CNT_W-1:0] ONE = TILE_CNT_W'(1);

    state_e                state_q;
    logic [2:0]            mask_q;
    logic [1:0]            mat_ptr_q;
    logic [TILE_CNT_W-1:0] tile_idx_q;
    logic [TILE_CNT_W-1:0] last_idx_q;
    slot_idx_t             wr_slot_q;
    slot_idx_t             tile_slot_q;
    logic [2:0]            sel_q;
    logic                  start_fetch_q;
    logic                  rst_addr_q;
    logic                  tile_valid_q;
    logic                  busy_q;
    logic                  done_q;

    logic [1:0] slot_full;
    logic [2:0] first_mat;
    logic [2:0] next_mat;
    logic       tile_set;

    assign first_mat = pick_mat(mat_mask_i, 2'd0);
    assign next_mat  = pick_mat(mask_q, mat_ptr_q + 2'd1);
    assign tile_set  = (state_q == WAIT_DONE) && fetch_done_i;

    pingpong_slot_tracker u_slots (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .abort_i   (abort_i),
        .set_i     (tile_set),
        .set_idx_i (wr_slot_q),
        .clr_i     (slot_release_i),
        .clr_idx_i (slot_release_idx_i),
        .full_o    (slot_full)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            mask_q        <= '0;
            mat_ptr_q     <= '0;
            tile_idx_q    <= '0;
            last_idx_q    <= '0;
            wr_slot_q     <= 1'b0;
            tile_slot_q   <= 1'b0;
            sel_q         <= '0;
            start_fetch_q <= 1'b0;
            rst_addr_q    <= 1'b0;
            tile_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else if (abort_i) begin
            state_q       <= IDLE;
            tile_idx_q    <= '0;
            wr_slot_q     <= 1'b0;
            start_fetch_q <= 1'b0;
            rst_addr_q    <= 1'b0;
            tile_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            start_fetch_q <= 1'b0;
            rst_addr_q    <= 1'b0;
            tile_valid_q  <= 1'b0;
            done_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (first_mat[2]) begin
                            mask_q     <= mat_mask_i;
                            last_idx_q <= (num_tiles_i == '0) ? '0
                                          : num_tiles_i - ONE;
                            mat_ptr_q  <= first_mat[1:0];
                            tile_idx_q <= '0;
                            sel_q      <= sel_code(first_mat[1:0]);
                            rst_addr_q <= 1'b1;
                            state_q    <= RST_ADDR;
                        end else begin
                            state_q <= FINISH;
                        end
                    end
                end
                RST_ADDR: state_q <= WAIT_SLOT;
                WAIT_SLOT: begin
                    if (!slot_full[wr_slot_q] && !fetch_busy_i) begin
                        start_fetch_q <= 1'b1;
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: state_q <= WAIT_DONE;
                WAIT_DONE: begin
                    if (fetch_done_i) begin
                        tile_valid_q <= 1'b1;
                        tile_slot_q  <= wr_slot_q;
                        wr_slot_q    <= ~wr_slot_q;
                        if (tile_idx_q < last_idx_q) begin
                            tile_idx_q <= tile_idx_q + ONE;
                            state_q    <= WAIT_SLOT;
                        end else if (next_mat[2]) begin
                            mat_ptr_q  <= next_mat[1:0];
                            tile_idx_q <= '0;
                            sel_q      <= sel_code(next_mat[1:0]);
                            rst_addr_q <= 1'b1;
                            state_q    <= RST_ADDR;
                        end else begin
                            state_q <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    // done is registered off FINISH, so it lands
                    // as the FSM returns to IDLE.
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_fetch_o        = start_fetch_q;
    assign reset_addr_counter_o = rst_addr_q;
    assign buffer_select_o      = sel_q;
    assign tiles_control_o      = tile_idx_q[0];
    assign double_buffering_o   = wr_slot_q;
    assign tile_valid_o         = tile_valid_q;
    assign tile_slot_o          = tile_slot_q;
    assign slot_full_o          = slot_full;
    assign busy_o               = busy_q;
    assign done_o               = done_q;

endmodule

// File: tb/tb_qkv_fetch_scheduler.sv
// Self-checking bench for qkv_fetch_scheduler: directed scenarios
// plus randomized runs against a tile-list reference model.
module tb_qkv_fetch_scheduler;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [2:0] mat_mask_i = '0;
    logic [7:0] num_tiles_i = '0;
    logic       fetch_done_i = 1'b0;
    logic       fetch_busy_i = 1'b0;
    logic       slot_release_i = 1'b0;
    logic       slot_release_idx_i = 1'b0;
    logic       start_fetch_o;
    logic       reset_addr_counter_o;
    logic [2:0] buffer_select_o;
    logic       tiles_control_o;
    logic       double_buffering_o;
    logic       tile_valid_o;
    logic       tile_slot_o;
    logic [1:0] slot_full_o;
    logic       busy_o;
    logic       done_o;

    int total = 0;
    int bad = 0;
    bit m_wr = 1'b0;

    typedef struct {
        logic [2:0] sel;
        logic       tc;
        logic       db;
    } exp_t;

    qkv_fetch_scheduler #(.TILE_CNT_W(8)) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .start_i              (start_i),
        .abort_i              (abort_i),
        .mat_mask_i           (mat_mask_i),
        .num_tiles_i          (num_tiles_i),
        .fetch_done_i         (fetch_done_i),
        .fetch_busy_i         (fetch_busy_i),
        .slot_release_i       (slot_release_i),
        .slot_release_idx_i   (slot_release_idx_i),
        .start_fetch_o        (start_fetch_o),
        .reset_addr_counter_o (reset_addr_counter_o),
        .buffer_select_o      (buffer_select_o),
        .tiles_control_o      (tiles_control_o),
        .double_buffering_o   (double_buffering_o),
        .tile_valid_o         (tile_valid_o),
        .tile_slot_o          (tile_slot_o),
        .slot_full_o          (slot_full_o),
        .busy_o               (busy_o),
        .done_o               (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [12:0] outs();
        return {start_fetch_o, reset_addr_counter_o, buffer_select_o,
                tiles_control_o, double_buffering_o, tile_valid_o,
                tile_slot_o, slot_full_o, busy_o, done_o};
    endfunction

    task automatic do_reset();
        rst_i = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        fetch_done_i = 1'b0;
        fetch_busy_i = 1'b0;
        slot_release_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        m_wr = 1'b0;
    endtask

    task automatic wait_sf(input string nm);
        for (int c = 0; c < 40; c++) begin
            if (start_fetch_o) break;
            tick();
        end
        total++;
        if (start_fetch_o !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout got=%0b want=1", nm, start_fetch_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        total++;
        if (outs() !== 13'd0) begin
            bad++;
            $display("FAIL reset_outs got=%h want=0", outs());
        end
        rst_i = 1'b0;
        m_wr = 1'b0;
    endtask

    // Model: tiles of each selected matrix in Q,K,V order, tile
    // parity on tiles_control, slot alternating over every tile.
    task automatic test_random(input logic [2:0] mask, input int n,
                               input int maxd);
        exp_t exp_q[$];
        bit   slot_q[$];
        bit   rel_s[$];
        int   rel_c[$];
        exp_t e;
        bit   es;
        bit   infl;
        bit   got_done;
        int   nt, nmat, rac, sfc, fd;
        nt = (n == 0) ? 1 : n;
        nmat = 0; rac = 0; sfc = 0; fd = 0;
        infl = 0; got_done = 0;
        for (int m = 0; m < 3; m++) begin
            if (mask[m]) begin
                nmat++;
                for (int t = 0; t < nt; t++) begin
                    e.sel = 3'(m);
                    e.tc = t[0];
                    e.db = m_wr;
                    exp_q.push_back(e);
                    m_wr = ~m_wr;
                end
            end
        end
        mat_mask_i = mask;
        num_tiles_i = 8'(n);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            fetch_done_i = 1'b0;
            slot_release_i = 1'b0;
            if (start_fetch_o) begin
                sfc++;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rnd_extra_fetch got=1 want=0");
                end else begin
                    e = exp_q.pop_front();
                    slot_q.push_back(e.db);
                    total++;
                    if (buffer_select_o !== e.sel) begin
                        bad++;
                        $display("FAIL rnd_sel got=%0d want=%0d",
                                 buffer_select_o, e.sel);
                    end
                    total++;
                    if (tiles_control_o !== e.tc) begin
                        bad++;
                        $display("FAIL rnd_tc got=%0b want=%0b",
                                 tiles_control_o, e.tc);
                    end
                    total++;
                    if (double_buffering_o !== e.db) begin
                        bad++;
                        $display("FAIL rnd_db got=%0b want=%0b",
                                 double_buffering_o, e.db);
                    end
                end
                fd = 2 + $urandom_range(maxd, 0);
                infl = 1;
                fetch_busy_i = 1'b1;
            end
            if (reset_addr_counter_o) rac++;
            if (tile_valid_o) begin
                es = (slot_q.size() > 0) ? slot_q.pop_front() : 1'b0;
                total++;
                if (tile_slot_o !== es) begin
                    bad++;
                    $display("FAIL rnd_tile_slot got=%0b want=%0b",
                             tile_slot_o, es);
                end
                rel_s.push_back(es);
                rel_c.push_back($urandom_range(maxd, 0));
            end
            if (done_o) begin
                got_done = 1;
                total++;
                if (busy_o !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_busy_at_done got=%0b want=0",
                             busy_o);
                end
            end
            if (infl) begin
                fd--;
                if (fd == 0) begin
                    fetch_done_i = 1'b1;
                    fetch_busy_i = 1'b0;
                    infl = 0;
                end
            end
            if (rel_s.size() > 0) begin
                if (rel_c[0] == 0) begin
                    slot_release_i = 1'b1;
                    slot_release_idx_i = rel_s.pop_front();
                    void'(rel_c.pop_front());
                end else begin
                    rel_c[0] = rel_c[0] - 1;
                end
            end
            if (got_done && rel_s.size() == 0 && !slot_release_i) break;
            tick();
        end
        fetch_done_i = 1'b0;
        slot_release_i = 1'b0;
        total++;
        if (!got_done) begin
            bad++;
            $display("FAIL rnd_done_timeout got=0 want=1");
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rnd_missing_fetches got=%0d want=0",
                     exp_q.size());
        end
        total++;
        if (sfc != nmat * nt) begin
            bad++;
            $display("FAIL rnd_fetch_count got=%0d want=%0d",
                     sfc, nmat * nt);
        end
        total++;
        if (rac != nmat) begin
            bad++;
            $display("FAIL rnd_rst_addr_count got=%0d want=%0d",
                     rac, nmat);
        end
        total++;
        if (slot_full_o !== 2'b00) begin
            bad++;
            $display("FAIL rnd_slots_drained got=%b want=00",
                     slot_full_o);
        end
    endtask

    task automatic test_stall_and_collision();
        int sf;
        int pend;
        do_reset();
        mat_mask_i = 3'b010;
        num_tiles_i = 8'd4;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        sf = 0;
        pend = 0;
        for (int c = 0; c < 30; c++) begin
            fetch_done_i = 1'b0;
            if (start_fetch_o) begin
                sf++;
                pend = 2;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) fetch_done_i = 1'b1;
            end
            tick();
        end
        fetch_done_i = 1'b0;
        total++;
        if (sf != 2) begin
            bad++;
            $display("FAIL stall_fetches got=%0d want=2", sf);
        end
        total++;
        if (slot_full_o !== 2'b11 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL stall_state got=%b/%b want=11/1",
                     slot_full_o, busy_o);
        end
        slot_release_i = 1'b1;
        slot_release_idx_i = 1'b0;
        tick();
        slot_release_i = 1'b0;
        total++;
        if (start_fetch_o !== 1'b0) begin
            bad++;
            $display("FAIL stall_early_fetch got=1 want=0");
        end
        tick();
        total++;
        if ({start_fetch_o, double_buffering_o, buffer_select_o,
             tiles_control_o} !== {1'b1, 1'b0, 3'd1, 1'b0}) begin
            bad++;
            $display("FAIL stall_resume got=%b%b%0d%b want=1010",
                     start_fetch_o, double_buffering_o,
                     buffer_select_o, tiles_control_o);
        end
        tick();
        fetch_done_i = 1'b1;
        slot_release_i = 1'b1;
        slot_release_idx_i = 1'b0;
        tick();
        fetch_done_i = 1'b0;
        slot_release_i = 1'b0;
        total++;
        if (slot_full_o !== 2'b11) begin
            bad++;
            $display("FAIL collide0 got=%b want=11", slot_full_o);
        end
        slot_release_i = 1'b1;
        slot_release_idx_i = 1'b1;
        tick();
        slot_release_i = 1'b0;
        tick();
        total++;
        if ({start_fetch_o, double_buffering_o, tiles_control_o}
            !== 3'b111) begin
            bad++;
            $display("FAIL slot1_fetch got=%b%b%b want=111",
                     start_fetch_o, double_buffering_o,
                     tiles_control_o);
        end
        tick();
        fetch_done_i = 1'b1;
        slot_release_i = 1'b1;
        slot_release_idx_i = 1'b1;
        tick();
        fetch_done_i = 1'b0;
        slot_release_i = 1'b0;
        total++;
        if ({slot_full_o, tile_valid_o, tile_slot_o} !== 4'b1111) begin
            bad++;
            $display("FAIL collide1 got=%b/%b/%b want=11/1/1",
                     slot_full_o, tile_valid_o, tile_slot_o);
        end
        tick();
        total++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL stall_done got=%b/%b want=1/0",
                     done_o, busy_o);
        end
    endtask

    task automatic test_abort();
        bit seen;
        do_reset();
        mat_mask_i = 3'b001;
        num_tiles_i = 8'd4;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_sf("abort_sf0");
        tick();
        fetch_done_i = 1'b1;
        tick();
        fetch_done_i = 1'b0;
        total++;
        if (slot_full_o !== 2'b01) begin
            bad++;
            $display("FAIL abort_pre got=%b want=01", slot_full_o);
        end
        wait_sf("abort_sf1");
        tick();
        abort_i = 1'b1;
        fetch_done_i = 1'b1;
        tick();
        abort_i = 1'b0;
        fetch_done_i = 1'b0;
        m_wr = 1'b0;
        total++;
        if ({busy_o, slot_full_o, double_buffering_o, tile_valid_o}
            !== 5'b0) begin
            bad++;
            $display("FAIL abort_state got=%b%b%b%b want=00000",
                     busy_o, slot_full_o, double_buffering_o,
                     tile_valid_o);
        end
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (done_o || start_fetch_o) seen = 1;
            tick();
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL abort_quiet got=1 want=0");
        end
    endtask

    task automatic test_empty_mask();
        mat_mask_i = 3'b000;
        num_tiles_i = 8'd3;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        total++;
        if (done_o !== 1'b0 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL empty_c1 got=%b/%b want=0/1", done_o, busy_o);
        end
        tick();
        total++;
        if (done_o !== 1'b1 || start_fetch_o !== 1'b0) begin
            bad++;
            $display("FAIL empty_c2 got=%b/%b want=1/0",
                     done_o, start_fetch_o);
        end
        tick();
        test_random(3'b001, 0, 2);
    endtask

    task automatic test_rst_mid();
        mat_mask_i = 3'b111;
        num_tiles_i = 8'd2;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_sf("rstmid_sf");
        rst_i = 1'b1;
        tick();
        total++;
        if (outs() !== 13'd0) begin
            bad++;
            $display("FAIL rstmid_outs got=%h want=0", outs());
        end
        rst_i = 1'b0;
        m_wr = 1'b0;
        test_random(3'b111, 2, 0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            test_random(3'($urandom_range(7, 1)),
                        $urandom_range(5, 0), $urandom_range(3, 0));
        end
    endtask

    initial begin
        test_reset();
        test_random(3'b111, 2, 0);
        test_stall_and_collision();
        test_abort();
        test_empty_mask();
        test_rst_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
